arcade_input_ctrl: RTL
======================

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 The module SHALL have parameter COIN_FRAMES, default 4, giving coin pulse length in frames (1..15).
REQ-002 The module SHALL have parameter GAP_FRAMES, default 2, giving frames between coin release and start assertion (0..15).
REQ-003 The module SHALL have parameter START_FRAMES, default 3, giving the minimum start pulse length in frames (1..15).
REQ-004 Port clk_sys, input, 1: the single clock; every register is clocked on its rising edge.
REQ-005 Port reset_n, input, 1: asynchronous active-low reset.
REQ-006 Port ps2_key, input, 65: keyboard event word; bit 64 toggles once per event, [15:8]=F0 marks a release, E0 in [15:8] or [23:16] marks an extended code, [7:0] is the scan code.
REQ-007 Port joystick_0 and port joystick_1, input, 16 each: bit0 R, bit1 L, bit2 D, bit3 U, bit4 fire, bit5 start1, bit6 start2.
REQ-008 Port rotate, input, 1: 1 selects horizontal orientation with remapped directions.
REQ-009 Port vblank, input, 1: vertical blank from the video core, used as the frame tick.
REQ-010 Port p1_csjudlr, output, 7, and port p2_csjudlr, output, 7: {coin,start,fire,up,down,left,right} to the game core; p2 coin is always 0.

Function
REQ-011 The module SHALL register bit 64 of ps2_key and treat a change in that bit as one key event, processed on the cycle the change is detected.
REQ-012 The module SHALL ignore an event when any bit of ps2_key[63:24] is set.
REQ-013 The module SHALL set a key latch to 1 on a press event and clear it to 0 on a release event, using these codes (X = either extended value):
- X75 up; X72 down; X6B left; X74 right
- 029 or 014 fire
- 005 start1; 006 start2
REQ-014 The module SHALL form each merged raw input as the key latch OR (joystick_0 | joystick_1) for that bit.
REQ-015 When rotate=0, directions SHALL pass straight through.
REQ-016 When rotate=1, the directions SHALL be remapped as: up=left_raw, down=right_raw, left=down_raw, right=up_raw.
REQ-017 Directions and fire SHALL be registered with 1-cycle latency and driven identically on p1 and p2.
REQ-018 A frame tick SHALL be a vblank 0->1 edge, detected with one register stage.
REQ-019 The coin sequencer SHALL be an FSM with states IDLE, COIN, GAP, START and HOLD, and a 4-bit frame counter.
REQ-020 IDLE: on a 0->1 edge of raw start1 or start2, the FSM SHALL latch the player (start1 wins if both edges coincide), load the counter and go to COIN.
REQ-021 COIN: coin SHALL be 1; after COIN_FRAMES ticks the FSM SHALL go to GAP, or straight to START when GAP_FRAMES=0.
REQ-022 GAP: after GAP_FRAMES ticks the FSM SHALL go to START.
REQ-023 START: start SHALL be 1 for the latched player only (p1 start for player 1, p2 start for player 2); after START_FRAMES ticks the FSM SHALL go to HOLD.
REQ-024 HOLD: start SHALL stay 1 while the latched raw start is held; on release the FSM SHALL return to IDLE.
REQ-025 Start edges arriving outside IDLE SHALL be discarded, not queued.
REQ-026 The counter SHALL decrement only on a frame tick and SHALL never wrap below 0.

Reset
REQ-027 While reset_n=0, all key latches, edge registers, the counter and both outputs SHALL be 0, and the FSM SHALL be in IDLE.
REQ-028 Asserting reset_n mid-sequence SHALL abort that sequence immediately.
REQ-029 A start that is still held after reset_n deasserts SHALL NOT trigger a sequence until it is released and pressed again.

Configuration
REQ-030 With INPUT_CTRL_KBD_EN defined, the keyboard decoding of REQ-011 to REQ-013 SHALL be compiled in.
REQ-031 Without INPUT_CTRL_KBD_EN, all key latches SHALL be constant 0, ps2_key SHALL be unused, and the inputs SHALL come from the joysticks only.

Verification
REQ-032 Scenario: ps2_key {toggle, 00,00,6B} then {toggle, F0 6B} with rotate=0 -> p1 left=1 one cycle after the first event, 0 one cycle after the second.
REQ-033 Scenario: joystick_0=0x0008 with rotate=1 -> p1_csjudlr=7'b0000001 (right only).
REQ-034 Scenario: joystick_1 bit6 pulsed, then 12 vblank ticks -> p1 coin=1 for exactly 4 ticks, then 2 ticks idle, then p2 start=1 for 3 ticks; p1 start stays 0.
REQ-035 Scenario: start1 and start2 edges in the same cycle -> the sequence latches player 1.
REQ-036 Scenario: reset_n pulsed low during COIN -> outputs 0 at once; with start held, no new sequence until release and re-press.
REQ-037 Scenario: build without INPUT_CTRL_KBD_EN, key 005 event -> outputs unchanged (all 0).

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges keyboard and two joysticks into the game core's
// {coin,start,fire,up,down,left,right} inputs, with optional rotation of the
// directions, and turns a start press into a timed coin/start sequence.
// Define INPUT_CTRL_KBD_EN to compile in the PS/2 keyboard decoder; without
// it the key latches are constant 0 and ps2_key is ignored.
module arcade_input_ctrl #(
  parameter int COIN_FRAMES  = 4,
  parameter int GAP_FRAMES   = 2,
  parameter int START_FRAMES = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [64:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  output logic [6:0]  p1_csjudlr,
  output logic [6:0]  p2_csjudlr
);

  localparam logic [3:0] CF = 4'(COIN_FRAMES);
  localparam logic [3:0] GF = 4'(GAP_FRAMES);
  localparam logic [3:0] SF = 4'(START_FRAMES);

  // key/raw bit order matches the joystick: 0 R, 1 L, 2 D, 3 U, 4 fire,
  // 5 start1, 6 start2
  logic [6:0] key_d;

`ifdef INPUT_CTRL_KBD_EN
  logic [6:0] key_q;
  logic       tog_q;
  logic       kbd_evt;
  logic       kbd_press;
  logic       unused_kbd;

  assign kbd_evt    = (ps2_key[64] != tog_q) && !(|ps2_key[63:24]);
  assign kbd_press  = (ps2_key[15:8] != 8'hF0);
  // extended prefix is irrelevant: every code is accepted either way
  assign unused_kbd = ^ps2_key[23:16];

  // decode the event into the key latches; the new value is used this cycle
  always_comb begin
    key_d = key_q;
    if (kbd_evt) begin
      case (ps2_key[7:0])
        8'h75:        key_d[3] = kbd_press;
        8'h72:        key_d[2] = kbd_press;
        8'h6B:        key_d[1] = kbd_press;
        8'h74:        key_d[0] = kbd_press;
        8'h29, 8'h14: key_d[4] = kbd_press;
        8'h05:        key_d[5] = kbd_press;
        8'h06:        key_d[6] = kbd_press;
        default:      ;
      endcase
    end
  end

  // toggle tracker and key latch state
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q <= 1'b0;
      key_q <= '0;
    end else begin
      tog_q <= ps2_key[64];
      key_q <= key_d;
    end
  end
`else
  logic unused_kbd;
  assign key_d      = '0;
  assign unused_kbd = ^ps2_key;
`endif

  logic [15:0] joy;
  logic [6:0]  raw;
  logic        unused_joy;
  logic        up_m, dn_m, lf_m, rt_m;

  assign joy        = joystick_0 | joystick_1;
  assign raw        = key_d | joy[6:0];
  assign unused_joy = ^joy[15:7];

  // horizontal cabinet: the stick is turned a quarter
  assign up_m = rotate ? raw[1] : raw[3];
  assign dn_m = rotate ? raw[0] : raw[2];
  assign lf_m = rotate ? raw[2] : raw[1];
  assign rt_m = rotate ? raw[3] : raw[0];

  logic [4:0] dir_q;   // {fire,up,down,left,right}
  logic       vbl_q;
  logic [1:0] st_q;    // previous raw start2/start1
  logic       armed_q; // blocks edges on the first cycle after reset
  logic       tick, e1, e2;

  assign tick = vblank & ~vbl_q;
  assign e1   = armed_q & raw[5] & ~st_q[0];
  assign e2   = armed_q & raw[6] & ~st_q[1];

  // direction/fire pipeline and edge detectors
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_q   <= '0;
      vbl_q   <= 1'b0;
      st_q    <= '0;
      armed_q <= 1'b0;
    end else begin
      dir_q   <= {raw[4], up_m, dn_m, lf_m, rt_m};
      vbl_q   <= vblank;
      st_q    <= raw[6:5];
      armed_q <= 1'b1;
    end
  end

  typedef enum logic [2:0] {IDLE, COIN, GAP, START, HOLD} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_dec;
  logic       plr_q, plr_d; // 0: player 1, 1: player 2
  logic       last_tick, held;

  assign cnt_dec   = (tick && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  assign last_tick = tick && (cnt_q <= 4'd1);
  assign held      = plr_q ? raw[6] : raw[5];

  // coin sequencer next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    plr_d   = plr_q;
    case (state_q)
      IDLE: begin
        if (e1) begin
          plr_d = 1'b0; cnt_d = CF; state_d = COIN;
        end else if (e2) begin
          plr_d = 1'b1; cnt_d = CF; state_d = COIN;
        end
      end
      COIN: begin
        if (last_tick) begin
          if (GF == 4'd0) begin
            cnt_d = SF; state_d = START;
          end else begin
            cnt_d = GF; state_d = GAP;
          end
        end else cnt_d = cnt_dec;
      end
      GAP: begin
        if (last_tick) begin
          cnt_d = SF; state_d = START;
        end else cnt_d = cnt_dec;
      end
      START: begin
        if (last_tick) begin
          cnt_d = 4'd0; state_d = HOLD;
        end else cnt_d = cnt_dec;
      end
      HOLD: begin
        if (!held) state_d = IDLE;
      end
      default: begin
        state_d = IDLE; cnt_d = 4'd0;
      end
    endcase
  end

  // coin sequencer state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      plr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plr_q   <= plr_d;
    end
  end

  logic coin, strt;
  assign coin = (state_q == COIN);
  assign strt = (state_q == START) || (state_q == HOLD);

  assign p1_csjudlr = {coin, strt & ~plr_q, dir_q};
  assign p2_csjudlr = {1'b0, strt & plr_q, dir_q};

endmodule
